// File: rtl/ofdm_rx_pkg.sv
// Shared types and constants for the OFDM receiver front-end control blocks.
// Holds the frame sequencer state encoding and a width helper.
package ofdm_rx_pkg;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StSync  = 2'd1,
        StPass  = 2'd2,
        StDrain = 2'd3
    } rx_state_e;

    // 256-point FFT plus 64-sample cyclic prefix
    localparam int unsigned DEFAULT_SYM_LEN = 320;
    localparam int unsigned DEFAULT_TIMEOUT = 4096;

    // Bits needed to hold values 0..value-1; never less than one bit.
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned bits;
        int unsigned rem;
        bits = 0;
        rem  = (value > 1) ? value - 1 : 0;
        while (rem != 0) begin
            bits = bits + 1;
            rem  = rem >> 1;
        end
        return (bits == 0) ? 1 : bits;
    endfunction

endpackage

// File: rtl/rx_sym_counter.sv
// Sample and symbol counters for one frame: marks the first sample of each
// symbol and flags the final accepted sample of the frame.
module rx_sym_counter
    import ofdm_rx_pkg::*;
#(
    parameter int unsigned SYM_LEN = DEFAULT_SYM_LEN,
    parameter int unsigned NSYM_W  = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              accept,
    input  logic [NSYM_W-1:0] n_sym_q,
    output logic              sym_start,
    output logic              last,
    output logic [NSYM_W-1:0] sym_idx
);

    localparam int unsigned      CW       = clog2(SYM_LEN);
    localparam logic [CW-1:0]    SAMP_MAX = CW'(SYM_LEN - 1);

    logic [CW-1:0]     r_samp_cnt;
    logic [CW-1:0]     w_samp_cnt_d;
    logic [NSYM_W-1:0] r_sym_idx;
    logic [NSYM_W-1:0] w_sym_idx_d;
    logic              w_wrap;
    logic              w_last_sym;

    assign w_wrap     = (r_samp_cnt == SAMP_MAX);
    assign w_last_sym = (r_sym_idx == (n_sym_q - NSYM_W'(1)));

    // Combinational so the marker travels with the sample it tags
    assign sym_start  = accept & (r_samp_cnt == '0);
    assign last       = accept & w_wrap & w_last_sym;
    assign sym_idx    = r_sym_idx;

    always_comb begin
        w_samp_cnt_d = r_samp_cnt;
        w_sym_idx_d  = r_sym_idx;
        if (clear) begin
            w_samp_cnt_d = '0;
            w_sym_idx_d  = '0;
        end else if (accept) begin
            if (w_wrap) begin
                w_samp_cnt_d = '0;
                // Index stays on the final symbol once the frame completes
                if (!w_last_sym) begin
                    w_sym_idx_d = r_sym_idx + NSYM_W'(1);
                end
            end else begin
                w_samp_cnt_d = r_samp_cnt + CW'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_samp_cnt <= '0;
            r_sym_idx  <= '0;
        end else begin
            r_samp_cnt <= w_samp_cnt_d;
            r_sym_idx  <= w_sym_idx_d;
        end
    end

endmodule

// File: rtl/rx_frame_sync_ctrl.sv
// Per-frame sequencer: burst detect, time-sync under timeout, then a gated
// window of a programmed number of OFDM symbols toward the demodulator.
module rx_frame_sync_ctrl
    import ofdm_rx_pkg::*;
#(
    parameter int unsigned SYM_LEN = DEFAULT_SYM_LEN,
    parameter int unsigned NSYM_W  = 5,
    parameter int unsigned TIMEOUT = DEFAULT_TIMEOUT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cyc_i,
    input  logic              stb_i,
    input  logic              ack_i,
    input  logic [NSYM_W-1:0] n_sym,
    output logic              syn_run,
    input  logic              syn_done,
    output logic              pass_en,
    output logic              sym_start,
    output logic [NSYM_W-1:0] sym_idx,
    output logic              frame_end,
    output logic              timeout_err,
    output logic              short_err,
    output logic              busy
);

    localparam int unsigned   TW        = clog2(TIMEOUT);
    localparam logic [TW-1:0] TIMER_MAX = TW'(TIMEOUT - 1);

    rx_state_e         r_state;
    rx_state_e         w_state_d;
    logic              r_cyc_q;
    logic [NSYM_W-1:0] r_n_sym;
    logic [TW-1:0]     r_timer;
    logic              r_frame_end;
    logic              r_timeout_err;
    logic              r_short_err;
    logic              w_frame_end_d;
    logic              w_timeout_d;
    logic              w_short_d;
    logic              w_rise;
    logic              w_accept;
    logic              w_cnt_accept;
    logic              w_clear;
    logic              w_last;

    assign w_rise       = cyc_i & ~r_cyc_q;
    assign w_accept     = stb_i & pass_en & ack_i;
    // Burst end in PASS wins over a coincident accept
    assign w_cnt_accept = w_accept & cyc_i;
    assign w_clear      = (r_state == StIdle) & w_rise;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= StIdle;
            r_frame_end   <= 1'b0;
            r_timeout_err <= 1'b0;
            r_short_err   <= 1'b0;
        end else begin
            r_state       <= w_state_d;
            r_frame_end   <= w_frame_end_d;
            r_timeout_err <= w_timeout_d;
            r_short_err   <= w_short_d;
        end
    end

    always_comb begin
        w_state_d     = r_state;
        w_frame_end_d = 1'b0;
        w_timeout_d   = 1'b0;
        w_short_d     = 1'b0;
        unique case (r_state)
            StIdle: begin
                if (w_rise) begin
                    w_state_d = StSync;
                end
            end
            StSync: begin
                if (!cyc_i) begin
                    w_state_d = StIdle;
                end else if (syn_done) begin
                    w_state_d = StPass;
                end else if (r_timer == TIMER_MAX) begin
                    w_state_d   = StDrain;
                    w_timeout_d = 1'b1;
                end
            end
            StPass: begin
                if (!cyc_i) begin
                    w_state_d = StIdle;
                    w_short_d = 1'b1;
                end else if (w_last) begin
                    w_state_d     = StDrain;
                    w_frame_end_d = 1'b1;
                end
            end
            StDrain: begin
                if (!cyc_i) begin
                    w_state_d = StIdle;
                end
            end
            default: begin
                w_state_d = StIdle;
            end
        endcase
    end

    always_comb begin
        syn_run     = (r_state == StSync);
        pass_en     = (r_state == StPass);
        busy        = (r_state != StIdle);
        frame_end   = r_frame_end;
        timeout_err = r_timeout_err;
        short_err   = r_short_err;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cyc_q <= 1'b0;
            r_n_sym <= NSYM_W'(1);
            r_timer <= '0;
        end else begin
            r_cyc_q <= cyc_i;
            if (w_clear) begin
                r_n_sym <= (n_sym == '0) ? NSYM_W'(1) : n_sym;
                r_timer <= '0;
            end else if (r_state == StSync) begin
                r_timer <= r_timer + TW'(1);
            end
        end
    end

    rx_sym_counter #(
        .SYM_LEN (SYM_LEN),
        .NSYM_W  (NSYM_W)
    ) u_sym_counter (
        .clk       (clk),
        .rst       (rst),
        .clear     (w_clear),
        .accept    (w_cnt_accept),
        .n_sym_q   (r_n_sym),
        .sym_start (sym_start),
        .last      (w_last),
        .sym_idx   (sym_idx)
    );

endmodule

// File: tb/tb_rx_frame_sync_ctrl.sv
// Directed bench for rx_frame_sync_ctrl with SYM_LEN=8, TIMEOUT=16.
module tb_rx_frame_sync_ctrl;

    logic       clk;
    logic       rst;
    logic       cyc_i;
    logic       stb_i;
    logic       ack_i;
    logic [4:0] n_sym;
    logic       syn_run;
    logic       syn_done;
    logic       pass_en;
    logic       sym_start;
    logic [4:0] sym_idx;
    logic       frame_end;
    logic       timeout_err;
    logic       short_err;
    logic       busy;

    int vectors;
    int miscompares;

    rx_frame_sync_ctrl #(
        .SYM_LEN (8),
        .NSYM_W  (5),
        .TIMEOUT (16)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .cyc_i       (cyc_i),
        .stb_i       (stb_i),
        .ack_i       (ack_i),
        .n_sym       (n_sym),
        .syn_run     (syn_run),
        .syn_done    (syn_done),
        .pass_en     (pass_en),
        .sym_start   (sym_start),
        .sym_idx     (sym_idx),
        .frame_end   (frame_end),
        .timeout_err (timeout_err),
        .short_err   (short_err),
        .busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
        $fatal(1, "watchdog");
    end

    function automatic logic [11:0] all_outs();
        return {syn_run, pass_en, sym_start, frame_end, timeout_err, short_err, busy, sym_idx};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic run_to_pass();
        cyc_i = 1'b1;
        step();
        syn_done = 1'b1;
        step();
        syn_done = 1'b0;
        #1;
    endtask

    task automatic to_idle();
        cyc_i = 1'b0;
        stb_i = 1'b0;
        ack_i = 1'b0;
        syn_done = 1'b0;
        step();
        step();
    endtask

    task automatic count_accepts(input int bound, output int acc);
        acc = 0;
        for (int c = 0; c < bound && pass_en === 1'b1; c++) begin
            if (stb_i && ack_i) acc++;
            step();
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        cyc_i = 1'b0; stb_i = 1'b0; ack_i = 1'b0; syn_done = 1'b0; n_sym = 5'd0;
        step();
        vectors++;
        if (all_outs() !== 12'h000) begin
            miscompares++;
            $display("FAIL reset_outputs: got %h required 000", all_outs());
        end
        rst = 1'b0;
        step();
        vectors++;
        if (busy !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_idle: busy got %b required 0", busy);
        end
    endtask

    task automatic test_nominal();
        n_sym = 5'd3; stb_i = 1'b1; ack_i = 1'b1;
        cyc_i = 1'b1;
        step();
        vectors++;
        if ({syn_run, pass_en, busy} !== 3'b101) begin
            miscompares++;
            $display("FAIL nom_sync_entry: got %b required 101", {syn_run, pass_en, busy});
        end
        repeat (4) step();
        syn_done = 1'b1;
        step();
        syn_done = 1'b0;
        #1;
        vectors++;
        if ({syn_run, pass_en} !== 2'b01) begin
            miscompares++;
            $display("FAIL nom_pass_entry: got %b required 01", {syn_run, pass_en});
        end
        for (int k = 0; k < 24; k++) begin
            vectors++;
            if (sym_start !== ((k % 8) == 0)) begin
                miscompares++;
                $display("FAIL nom_sym_start[%0d]: got %b required %b", k, sym_start, (k % 8) == 0);
            end
            vectors++;
            if ({pass_en, frame_end, sym_idx} !== {2'b10, 5'(k / 8)}) begin
                miscompares++;
                $display("FAIL nom_pass[%0d]: got %b required %b", k,
                         {pass_en, frame_end, sym_idx}, {2'b10, 5'(k / 8)});
            end
            step();
        end
        vectors++;
        if ({frame_end, pass_en, busy, sym_idx} !== {3'b101, 5'd2}) begin
            miscompares++;
            $display("FAIL nom_frame_end: got %b required 10100010", {frame_end, pass_en, busy, sym_idx});
        end
        step();
        vectors++;
        if ({frame_end, busy, sym_idx} !== {2'b01, 5'd2}) begin
            miscompares++;
            $display("FAIL nom_drain: got %b required 0100010", {frame_end, busy, sym_idx});
        end
        cyc_i = 1'b0;
        step();
        vectors++;
        if (busy !== 1'b0) begin
            miscompares++;
            $display("FAIL nom_idle: busy got %b required 0", busy);
        end
        to_idle();
    endtask

    task automatic test_timeout();
        n_sym = 5'd1; stb_i = 1'b1; ack_i = 1'b1;
        cyc_i = 1'b1;
        step();
        for (int i = 1; i < 16; i++) begin
            step();
            vectors++;
            if ({timeout_err, syn_run, pass_en} !== 3'b010) begin
                miscompares++;
                $display("FAIL to_wait[%0d]: got %b required 010", i, {timeout_err, syn_run, pass_en});
            end
        end
        step();
        vectors++;
        if ({timeout_err, syn_run, pass_en, busy} !== 4'b1001) begin
            miscompares++;
            $display("FAIL to_pulse: got %b required 1001", {timeout_err, syn_run, pass_en, busy});
        end
        syn_done = 1'b1;
        step();
        syn_done = 1'b0;
        vectors++;
        if ({timeout_err, pass_en, syn_run, busy} !== 4'b0001) begin
            miscompares++;
            $display("FAIL to_done_in_drain: got %b required 0001", {timeout_err, pass_en, syn_run, busy});
        end
        cyc_i = 1'b0;
        step();
        vectors++;
        if (busy !== 1'b0) begin
            miscompares++;
            $display("FAIL to_idle: busy got %b required 0", busy);
        end
        syn_done = 1'b1;
        step();
        syn_done = 1'b0;
        vectors++;
        if ({busy, syn_run, pass_en} !== 3'b000) begin
            miscompares++;
            $display("FAIL to_done_in_idle: got %b required 000", {busy, syn_run, pass_en});
        end
        to_idle();
    endtask

    task automatic test_short();
        n_sym = 5'd2; stb_i = 1'b1; ack_i = 1'b1;
        run_to_pass();
        repeat (10) step();
        vectors++;
        if ({pass_en, sym_idx} !== {1'b1, 5'd1}) begin
            miscompares++;
            $display("FAIL short_mid: got %b required 100001", {pass_en, sym_idx});
        end
        cyc_i = 1'b0;
        step();
        vectors++;
        if ({short_err, frame_end, busy, pass_en} !== 4'b1000) begin
            miscompares++;
            $display("FAIL short_pulse: got %b required 1000", {short_err, frame_end, busy, pass_en});
        end
        step();
        vectors++;
        if ({short_err, frame_end, busy} !== 3'b000) begin
            miscompares++;
            $display("FAIL short_after: got %b required 000", {short_err, frame_end, busy});
        end
        to_idle();
    endtask

    task automatic test_backpressure();
        int acc;
        n_sym = 5'd2; stb_i = 1'b1; ack_i = 1'b0;
        run_to_pass();
        acc = 0;
        for (int c = 0; c < 64 && pass_en === 1'b1; c++) begin
            ack_i = ((c % 2) == 0);
            #1;
            vectors++;
            if (sym_start !== (ack_i && (acc % 8) == 0)) begin
                miscompares++;
                $display("FAIL bp_sym_start[%0d]: got %b required %b", c, sym_start,
                         ack_i && (acc % 8) == 0);
            end
            vectors++;
            if (sym_idx !== 5'(acc / 8)) begin
                miscompares++;
                $display("FAIL bp_sym_idx[%0d]: got %0d required %0d", c, sym_idx, acc / 8);
            end
            if (ack_i) acc++;
            step();
        end
        vectors++;
        if ({pass_en, frame_end} !== 2'b01 || acc != 16) begin
            miscompares++;
            $display("FAIL bp_count: accepts %0d pass_en %b frame_end %b required 16 0 1",
                     acc, pass_en, frame_end);
        end
        to_idle();
    endtask

    task automatic test_nsym_zero();
        int acc;
        n_sym = 5'd0; stb_i = 1'b1; ack_i = 1'b1;
        run_to_pass();
        count_accepts(32, acc);
        vectors++;
        if (acc != 8 || frame_end !== 1'b1 || sym_idx !== 5'd0) begin
            miscompares++;
            $display("FAIL nsym0: accepts %0d frame_end %b sym_idx %0d required 8 1 0",
                     acc, frame_end, sym_idx);
        end
        to_idle();
    endtask

    task automatic test_done_and_fall();
        n_sym = 5'd1; stb_i = 1'b1; ack_i = 1'b1;
        cyc_i = 1'b1;
        step();
        syn_done = 1'b1;
        cyc_i = 1'b0;
        step();
        syn_done = 1'b0;
        vectors++;
        if ({busy, pass_en, syn_run, timeout_err, short_err} !== 5'b00000) begin
            miscompares++;
            $display("FAIL done_fall: got %b required 00000",
                     {busy, pass_en, syn_run, timeout_err, short_err});
        end
        to_idle();
    endtask

    task automatic test_async_reset();
        n_sym = 5'd2; stb_i = 1'b1; ack_i = 1'b1;
        run_to_pass();
        repeat (3) step();
        #2;
        rst = 1'b1;
        #1;
        vectors++;
        if (all_outs() !== 12'h000) begin
            miscompares++;
            $display("FAIL async_rst: got %h required 000", all_outs());
        end
        cyc_i = 1'b0;
        step();
        rst = 1'b0;
        step();
        vectors++;
        if (busy !== 1'b0) begin
            miscompares++;
            $display("FAIL async_rst_idle: busy got %b required 0", busy);
        end
        to_idle();
    endtask

    task automatic test_back_to_back();
        int acc;
        n_sym = 5'd2; stb_i = 1'b1; ack_i = 1'b1;
        run_to_pass();
        repeat (16) step();
        vectors++;
        if ({frame_end, sym_idx} !== {1'b1, 5'd1}) begin
            miscompares++;
            $display("FAIL b2b_first_end: got %b required 100001", {frame_end, sym_idx});
        end
        cyc_i = 1'b0;
        step();
        vectors++;
        if (busy !== 1'b0) begin
            miscompares++;
            $display("FAIL b2b_gap_idle: busy got %b required 0", busy);
        end
        cyc_i = 1'b1;
        step();
        vectors++;
        if ({syn_run, sym_idx} !== {1'b1, 5'd0}) begin
            miscompares++;
            $display("FAIL b2b_restart: got %b required 100000", {syn_run, sym_idx});
        end
        syn_done = 1'b1;
        step();
        syn_done = 1'b0;
        #1;
        vectors++;
        if ({pass_en, sym_start} !== 2'b11) begin
            miscompares++;
            $display("FAIL b2b_first_sym: got %b required 11", {pass_en, sym_start});
        end
        count_accepts(40, acc);
        vectors++;
        if (acc != 16 || frame_end !== 1'b1) begin
            miscompares++;
            $display("FAIL b2b_second_frame: accepts %0d frame_end %b required 16 1", acc, frame_end);
        end
        to_idle();
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        test_reset();
        test_nominal();
        test_timeout();
        test_short();
        test_backpressure();
        test_nsym_zero();
        test_done_and_fall();
        test_async_reset();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
